// File: rtl/laser_sync_sequencer_if.sv
// Control and status bundle for the laser interleave sequencer.
// The master drives sync, step and mode inputs; the slave returns laser and phase status.
interface laser_sync_sequencer_if #(
    parameter int unsigned NUM_LASERS = 2,
    parameter int unsigned PHASE_BITS = 4
);
    logic                  v_sync;
    logic                  step_up;
    logic                  step_dn;
    logic                  rotate;
    logic                  enable;
    logic [NUM_LASERS-1:0] laser_en;
    logic                  vsync_dly;
    logic [PHASE_BITS-1:0] phase_idx;
    logic [PHASE_BITS-1:0] phase_pend;
    logic                  tick;

    modport master (
        output v_sync, step_up, step_dn, rotate, enable,
        input  laser_en, vsync_dly, phase_idx, phase_pend, tick
    );

    modport slave (
        input  v_sync, step_up, step_dn, rotate, enable,
        output laser_en, vsync_dly, phase_idx, phase_pend, tick
    );
endinterface

// File: rtl/laser_sync_sequencer.sv
// Laser interleave sequencer: synchronises camera V_SYNC, delays it by a staged
// phase tap and rotates one-hot laser enables on every delayed-sync edge.
module laser_sync_sequencer #(
    parameter int unsigned NUM_LASERS = 2,
    parameter int unsigned PHASE_BITS = 4,
    parameter int unsigned DIV        = 62500
) (
    input logic                   clk_30Mhz,
    input logic                   rst_n,
    laser_sync_sequencer_if.slave bus
);
    localparam int unsigned IDX_W  = (NUM_LASERS > 2) ? $clog2(NUM_LASERS) : 1;
    localparam int unsigned PHASES = 2 ** PHASE_BITS;
    localparam int unsigned CNT_W  = (DIV > 2) ? $clog2(DIV) : 1;

    logic                  s1, s2, s2_d, fb;
    logic [CNT_W-1:0]      cnt;
    logic                  tick;
    logic [PHASES-1:0]     taps;
    logic                  vsync_dly, vd_d, dly_edge;
    logic [PHASE_BITS-1:0] phase_idx, phase_pend, pend_next;
    logic [IDX_W-1:0]      li, li_next;
    logic [NUM_LASERS-1:0] laser_en;

    // Two-flop synchroniser plus a delay stage for frame-boundary detection
    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= bus.v_sync;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // tick is registered one cycle early so it is high exactly while cnt == DIV-1
    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= (cnt == CNT_W'(DIV - 1)) ? '0 : cnt + CNT_W'(1);
            tick <= (cnt == CNT_W'(DIV - 2));
        end
    end

    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            taps <= '0;
        end else if (tick) begin
            taps <= {taps[PHASES-2:0], s2};
        end
    end

    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            vsync_dly <= 1'b0;
            vd_d      <= 1'b0;
        end else begin
            vsync_dly <= taps[phase_idx];
            vd_d      <= vsync_dly;
        end
    end

    always_comb begin
        fb        = s2 & ~s2_d;
        dly_edge  = vsync_dly ^ vd_d;
        pend_next = phase_pend;
        li_next   = li;
        if (bus.step_up && !bus.step_dn) begin
            pend_next = phase_pend + PHASE_BITS'(1);
        end else if (bus.step_dn && !bus.step_up) begin
            pend_next = phase_pend - PHASE_BITS'(1);
        end
        if (dly_edge && bus.rotate) begin
            li_next = (li == IDX_W'(NUM_LASERS - 1)) ? '0 : li + IDX_W'(1);
        end
    end

    // Commit takes the pending value from before any same-cycle step
    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            phase_pend <= '0;
            phase_idx  <= '0;
        end else begin
            phase_pend <= pend_next;
            if (fb) begin
                phase_idx <= phase_pend;
            end
        end
    end

    // Enables follow li_next so they change one edge after the delayed sync
    always_ff @(posedge clk_30Mhz or negedge rst_n) begin
        if (!rst_n) begin
            li       <= '0;
            laser_en <= '0;
        end else begin
            li       <= li_next;
            laser_en <= bus.enable ? (NUM_LASERS'(1) << li_next) : '0;
        end
    end

    assign bus.laser_en   = laser_en;
    assign bus.vsync_dly  = vsync_dly;
    assign bus.phase_idx  = phase_idx;
    assign bus.phase_pend = phase_pend;
    assign bus.tick       = tick;

endmodule
